// File: rtl/reset_ctrl.sv
// Keyboard-driven reset controller: debounces F12/F11 request levels and sequences
// power-on, warm and cold resets with a stretched cpu_rst release.
module reset_ctrl #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLD     = 4096,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic key_reset,
    input  logic key_boot,
    output logic cpu_rst,
    output logic cold,
    output logic busy
);

    localparam logic [1:0] POR     = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [1:0] STRETCH = 2'd3;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             kr_d;
    logic             kb_d;
    logic [CNT_W-1:0] kr_cnt;
    logic [CNT_W-1:0] kb_cnt;

    // Accepted level flips on the DEBOUNCE-th consecutive differing tick; agreement restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            kr_d   <= 1'b1;
            kb_d   <= 1'b1;
            kr_cnt <= '0;
            kb_cnt <= '0;
        end else if (ce) begin
            if (key_reset == kr_d) begin
                kr_cnt <= '0;
            end else if (kr_cnt == DB_LAST) begin
                kr_d   <= key_reset;
                kr_cnt <= '0;
            end else begin
                kr_cnt <= kr_cnt + 1'b1;
            end

            if (key_boot == kb_d) begin
                kb_cnt <= '0;
            end else if (kb_cnt == DB_LAST) begin
                kb_d   <= key_boot;
                kb_cnt <= '0;
            end else begin
                kb_cnt <= kb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= POR;
            cnt     <= '0;
            cpu_rst <= 1'b1;
            cold    <= 1'b1;
            busy    <= 1'b1;
        end else if (ce) begin
            case (state)
                POR: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= RUN;
                        cnt     <= '0;
                        cpu_rst <= 1'b0;
                        cold    <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!kb_d || !kr_d) begin
                        state   <= HELD;
                        cpu_rst <= 1'b1;
                        busy    <= 1'b1;
                        cold    <= !kb_d;
                    end
                end
                HELD: begin
                    // cold only ever upgrades until the sequence ends in RUN
                    if (!kb_d) cold <= 1'b1;
                    if (kr_d && kb_d) begin
                        state <= STRETCH;
                        cnt   <= '0;
                    end
                end
                STRETCH: begin
                    if (!kr_d || !kb_d) begin
                        state <= HELD;
                        cnt   <= '0;
                        if (!kb_d) cold <= 1'b1;
                    end else if (cnt == HOLD_LAST) begin
                        state   <= RUN;
                        cnt     <= '0;
                        cpu_rst <= 1'b0;
                        cold    <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= POR;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl with DEBOUNCE=4, HOLD=8; expected values are hand-derived tick counts.
module tb_reset_ctrl;

    logic clock = 1'b0;
    logic reset;
    logic ce;
    logic key_reset;
    logic key_boot;
    logic cpu_rst;
    logic cold;
    logic busy;

    int checks = 0;
    int errors = 0;

    reset_ctrl #(.DEBOUNCE(4), .HOLD(8), .CNT_W(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .ce       (ce),
        .key_reset(key_reset),
        .key_boot (key_boot),
        .cpu_rst  (cpu_rst),
        .cold     (cold),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic outs(input string tag, input logic r, input logic c, input logic b);
        check({tag, ".cpu_rst"}, cpu_rst, r);
        check({tag, ".cold"}, cold, c);
        check({tag, ".busy"}, busy, b);
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b1;
        key_reset = 1'b1;
        key_boot = 1'b1;
        #2;
        outs("por_in_reset", 1'b1, 1'b1, 1'b1);
        tick(2);
        outs("por_held", 1'b1, 1'b1, 1'b1);
        reset = 1'b0;

        // 1. power-on: 8 ce ticks of reset after release
        tick(7);
        outs("por_tick7", 1'b1, 1'b1, 1'b1);
        tick(1);
        outs("por_run", 1'b0, 1'b0, 1'b0);

        // 2. warm reset
        key_reset = 1'b0;
        tick(4);
        check("warm_tick4", cpu_rst, 1'b0);
        tick(1);
        outs("warm_held", 1'b1, 1'b0, 1'b1);
        tick(15);
        key_reset = 1'b1;
        tick(12);
        outs("warm_stretch_end", 1'b1, 1'b0, 1'b1);
        tick(1);
        outs("warm_run", 1'b0, 1'b0, 1'b0);

        // 3. bounce never accepted
        for (int p = 0; p < 10; p++) begin
            key_reset = 1'b0;
            tick(1); check("bounce", cpu_rst, 1'b0);
            tick(1); check("bounce", cpu_rst, 1'b0);
            key_reset = 1'b1;
            tick(1); check("bounce", cpu_rst, 1'b0);
            tick(1); check("bounce", cpu_rst, 1'b0);
        end
        tick(5);
        outs("bounce_after", 1'b0, 1'b0, 1'b0);

        // 4a. warm then upgraded to cold while HELD
        key_reset = 1'b0;
        tick(5);
        outs("upg_warm", 1'b1, 1'b0, 1'b1);
        key_boot = 1'b0;
        tick(4);
        check("upg_tick4.cold", cold, 1'b0);
        tick(1);
        outs("upg_cold", 1'b1, 1'b1, 1'b1);
        tick(3);
        key_reset = 1'b1;
        key_boot = 1'b1;
        tick(12);
        outs("upg_stretch_end", 1'b1, 1'b1, 1'b1);
        tick(1);
        outs("upg_run", 1'b0, 1'b0, 1'b0);

        // 4b. both keys together from RUN
        key_reset = 1'b0;
        key_boot = 1'b0;
        tick(4);
        check("both_tick4", cpu_rst, 1'b0);
        tick(1);
        outs("both_held", 1'b1, 1'b1, 1'b1);
        key_reset = 1'b1;
        key_boot = 1'b1;
        tick(12);
        outs("both_stretch_end", 1'b1, 1'b1, 1'b1);
        tick(1);
        outs("both_run", 1'b0, 1'b0, 1'b0);

        // 5. re-press during STRETCH restarts the full stretch
        key_reset = 1'b0;
        tick(10);
        key_reset = 1'b1;
        tick(5);
        key_reset = 1'b0;
        tick(10);
        outs("repress_held", 1'b1, 1'b0, 1'b1);
        key_reset = 1'b1;
        tick(12);
        outs("repress_stretch_end", 1'b1, 1'b0, 1'b1);
        tick(1);
        outs("repress_run", 1'b0, 1'b0, 1'b0);

        // 6a. ce gating freezes STRETCH (counter at 3)
        key_reset = 1'b0;
        tick(5);
        key_reset = 1'b1;
        tick(8);
        ce = 1'b0;
        tick(100);
        outs("ce_frozen", 1'b1, 1'b0, 1'b1);
        ce = 1'b1;
        tick(4);
        outs("ce_resume4", 1'b1, 1'b0, 1'b1);
        tick(1);
        outs("ce_run", 1'b0, 1'b0, 1'b0);

        // 6b. async reset mid-STRETCH
        key_reset = 1'b0;
        tick(5);
        key_reset = 1'b1;
        tick(7);
        #2;
        reset = 1'b1;
        #1;
        outs("async_abort", 1'b1, 1'b1, 1'b1);
        tick(2);
        reset = 1'b0;
        tick(7);
        outs("async_por7", 1'b1, 1'b1, 1'b1);
        tick(1);
        outs("async_run", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
